// File: rtl/action_phv_merger.sv
// Rebuilds one PHV from the independently timed 6B/4B/2B ALU result groups plus metadata.
// Optional partial-collection timeout is compiled in with `define ACTION_MERGE_TIMEOUT_EN.
module action_phv_merger #(
  parameter int STAGE_ID       = 0,
  parameter int NUM_PER_TYPE   = 8,
  parameter int width_2B       = 16,
  parameter int width_4B       = 32,
  parameter int width_6B       = 48,
  parameter int PHV_LEN        = 48*NUM_PER_TYPE + 32*NUM_PER_TYPE + 16*NUM_PER_TYPE + 256,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [width_6B*NUM_PER_TYPE-1:0] alu_6B_in,
  input  logic                             alu_6B_valid,
  input  logic [width_4B*NUM_PER_TYPE-1:0] alu_4B_in,
  input  logic                             alu_4B_valid,
  input  logic [width_2B*NUM_PER_TYPE-1:0] alu_2B_in,
  input  logic [255:0]                     phv_remain_in,
  input  logic                             alu_2B_valid,
  output logic                             ready_out,
  output logic [PHV_LEN-1:0]               phv_out,
  output logic                             phv_out_valid,
  input  logic                             ready_in,
  output logic [15:0]                      drop_cnt,
  output logic                             timeout_err
);

  localparam int W6 = width_6B * NUM_PER_TYPE;
  localparam int W4 = width_4B * NUM_PER_TYPE;
  localparam int W2 = width_2B * NUM_PER_TYPE;

  // Handshakes: a group is taken on any edge where its valid is high while ready_out is high;
  // phv_out transfers on an edge where phv_out_valid and ready_in are both high.
  typedef enum logic {COLLECT = 1'b0, EMIT = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [2:0]      flags_q, flags_d;   // {6B, 4B, 2B}
  logic [W6-1:0]   hold_6b_q, hold_6b_d;
  logic [W4-1:0]   hold_4b_q, hold_4b_d;
  logic [W2-1:0]   hold_2b_q, hold_2b_d;
  logic [255:0]    hold_rem_q, hold_rem_d;
  logic [PHV_LEN-1:0] phv_out_q, phv_out_d;
  logic            phv_valid_q, phv_valid_d;
  logic            ready_q, ready_d;
  logic [15:0]     drop_cnt_q, drop_cnt_d;

  logic [2:0]      grp_valid;
  logic [2:0]      drop_vec;
  logic [1:0]      drop_num;
  logic [16:0]     drop_sum;
  logic            complete;
  logic            timeout_fire;

  // Parameter sanity hook; intentionally empty.
  if (TIMEOUT_CYCLES < 2 || STAGE_ID < 0) begin : g_param_note
  end

  assign grp_valid = {alu_6B_valid, alu_4B_valid, alu_2B_valid};
  assign complete  = (state_q == COLLECT) && (&(flags_q | grp_valid));

  always_comb begin
    state_d     = state_q;
    flags_d     = flags_q;
    hold_6b_d   = hold_6b_q;
    hold_4b_d   = hold_4b_q;
    hold_2b_d   = hold_2b_q;
    hold_rem_d  = hold_rem_q;
    phv_out_d   = phv_out_q;
    phv_valid_d = phv_valid_q;
    ready_d     = ready_q;
    drop_vec    = 3'b000;
    case (state_q)
      COLLECT: begin
        drop_vec = grp_valid & flags_q;
        if (alu_6B_valid && !flags_q[2]) hold_6b_d = alu_6B_in;
        if (alu_4B_valid && !flags_q[1]) hold_4b_d = alu_4B_in;
        if (alu_2B_valid && !flags_q[0]) begin
          hold_2b_d  = alu_2B_in;
          hold_rem_d = phv_remain_in;
        end
        flags_d = flags_q | grp_valid;
        // Completion wins over a timeout landing in the same cycle.
        if (complete) begin
          state_d     = EMIT;
          phv_out_d   = {hold_6b_d, hold_4b_d, hold_2b_d, hold_rem_d};
          phv_valid_d = 1'b1;
          ready_d     = 1'b0;
        end else if (timeout_fire) begin
          flags_d = 3'b000;
        end
      end
      EMIT: begin
        drop_vec = grp_valid;
        if (ready_in) begin
          state_d     = COLLECT;
          flags_d     = 3'b000;
          phv_valid_d = 1'b0;
          ready_d     = 1'b1;
        end
      end
      default: begin
        state_d = COLLECT;
        flags_d = 3'b000;
        ready_d = 1'b1;
      end
    endcase
  end

  assign drop_num   = {1'b0, drop_vec[2]} + {1'b0, drop_vec[1]} + {1'b0, drop_vec[0]};
  assign drop_sum   = {1'b0, drop_cnt_q} + {15'b0, drop_num};
  assign drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= COLLECT;
      flags_q     <= 3'b000;
      hold_6b_q   <= '0;
      hold_4b_q   <= '0;
      hold_2b_q   <= '0;
      hold_rem_q  <= '0;
      phv_out_q   <= '0;
      phv_valid_q <= 1'b0;
      ready_q     <= 1'b1;
      drop_cnt_q  <= 16'h0000;
    end else begin
      state_q     <= state_d;
      flags_q     <= flags_d;
      hold_6b_q   <= hold_6b_d;
      hold_4b_q   <= hold_4b_d;
      hold_2b_q   <= hold_2b_d;
      hold_rem_q  <= hold_rem_d;
      phv_out_q   <= phv_out_d;
      phv_valid_q <= phv_valid_d;
      ready_q     <= ready_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

`ifdef ACTION_MERGE_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
  logic             to_err_q, to_err_d;

  // Counter restarts when the first group of a PHV lands and runs while the set is partial.
  always_comb begin
    to_cnt_d     = to_cnt_q;
    to_err_d     = 1'b0;
    timeout_fire = 1'b0;
    if (state_q == COLLECT) begin
      if (flags_q == 3'b000) begin
        if (|grp_valid) to_cnt_d = '0;
      end else if (!complete) begin
        if (to_cnt_q == CNT_LIMIT) begin
          timeout_fire = 1'b1;
          to_err_d     = 1'b1;
          to_cnt_d     = '0;
        end else begin
          to_cnt_d = to_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q <= '0;
      to_err_q <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      to_err_q <= to_err_d;
    end
  end

  assign timeout_err = to_err_q;
`else
  assign timeout_fire = 1'b0;
  assign timeout_err  = 1'b0;
`endif

  assign ready_out     = ready_q;
  assign phv_out       = phv_out_q;
  assign phv_out_valid = phv_valid_q;
  assign drop_cnt      = drop_cnt_q;

endmodule

// File: tb/tb_action_phv_merger.sv
// Directed bench for action_phv_merger: expected PHVs are queued at stimulus time and
// popped by an independent monitor on every output handshake.
module tb_action_phv_merger;

  localparam int N     = 8;
  localparam int W6    = 48 * N;
  localparam int W4    = 32 * N;
  localparam int W2    = 16 * N;
  localparam int WR    = 256;
  localparam int PHV_W = W6 + W4 + W2 + WR;
`ifdef ACTION_MERGE_TIMEOUT_EN
  localparam int TB_TO = 8;
`else
  localparam int TB_TO = 64;
`endif

  logic             clk;
  logic             rst_n;
  logic [W6-1:0]    alu_6B_in;
  logic             alu_6B_valid;
  logic [W4-1:0]    alu_4B_in;
  logic             alu_4B_valid;
  logic [W2-1:0]    alu_2B_in;
  logic [WR-1:0]    phv_remain_in;
  logic             alu_2B_valid;
  logic             ready_out;
  logic [PHV_W-1:0] phv_out;
  logic             phv_out_valid;
  logic             ready_in;
  logic [15:0]      drop_cnt;
  logic             timeout_err;

  int n_checks = 0;
  int n_errors = 0;
  logic [PHV_W-1:0] exp_q[$];
  logic [PHV_W-1:0] mon_exp;

  action_phv_merger #(
    .STAGE_ID(0), .NUM_PER_TYPE(N), .width_2B(16), .width_4B(32), .width_6B(48),
    .PHV_LEN(PHV_W), .TIMEOUT_CYCLES(TB_TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_6B_in(alu_6B_in), .alu_6B_valid(alu_6B_valid),
    .alu_4B_in(alu_4B_in), .alu_4B_valid(alu_4B_valid),
    .alu_2B_in(alu_2B_in), .phv_remain_in(phv_remain_in), .alu_2B_valid(alu_2B_valid),
    .ready_out(ready_out), .phv_out(phv_out), .phv_out_valid(phv_out_valid),
    .ready_in(ready_in), .drop_cnt(drop_cnt), .timeout_err(timeout_err)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [PHV_W-1:0] rep(input logic [7:0] b);
    logic [PHV_W-1:0] r;
    for (int i = 0; i < PHV_W / 8; i++) r[i*8 +: 8] = b;
    return r;
  endfunction

  function automatic logic [PHV_W-1:0] mk(input logic [7:0] b6, b4, b2, br);
    logic [PHV_W-1:0] t6, t4, t2, tr;
    t6 = rep(b6); t4 = rep(b4); t2 = rep(b2); tr = rep(br);
    return {t6[W6-1:0], t4[W4-1:0], t2[W2-1:0], tr[WR-1:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_wide(input string name, input logic [PHV_W-1:0] act,
                            input logic [PHV_W-1:0] exp);
    int idx;
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      idx = 0;
      for (int i = PHV_W / 64 - 1; i >= 0; i--)
        if (act[i*64 +: 64] !== exp[i*64 +: 64]) idx = i;
      $display("FAIL %s: word %0d got 0x%h want 0x%h", name, idx,
               act[idx*64 +: 64], exp[idx*64 +: 64]);
    end
  endtask

  // Driver tasks
  task automatic set_in(input logic v6, v4, v2, input logic [7:0] b6, b4, b2, br);
    logic [PHV_W-1:0] t;
    t = rep(b6); alu_6B_in     = t[W6-1:0];
    t = rep(b4); alu_4B_in     = t[W4-1:0];
    t = rep(b2); alu_2B_in     = t[W2-1:0];
    t = rep(br); phv_remain_in = t[WR-1:0];
    alu_6B_valid = v6;
    alu_4B_valid = v4;
    alu_2B_valid = v2;
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cycle(input logic v6, v4, v2, input logic [7:0] b6, b4, b2, br);
    set_in(v6, v4, v2, b6, b4, b2, br);
    sync();
    alu_6B_valid = 1'b0;
    alu_4B_valid = 1'b0;
    alu_2B_valid = 1'b0;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && phv_out_valid && ready_in) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_phv: got an output beat, want none");
      end else begin
        mon_exp = exp_q.pop_front();
        check_wide("phv_out", phv_out, mon_exp);
      end
    end
  end

  initial begin
    #1000000;
    n_errors++;
    $display("FAIL watchdog: got no end of test, want completion");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    rst_n = 1'b1;
    ready_in = 1'b1;
    set_in(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    #1 rst_n = 1'b0;
    #1;
    check("rst_valid", 32'(phv_out_valid), 32'd0);
    check("rst_ready_out", 32'(ready_out), 32'd1);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    check_wide("rst_phv_out", phv_out, '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    sync();

    // All three groups in one cycle
    exp_q.push_back(mk(8'h11, 8'h22, 8'h33, 8'hAB));
    drive_cycle(1'b1, 1'b1, 1'b1, 8'h11, 8'h22, 8'h33, 8'hAB);
    @(negedge clk);
    check("t1_valid_rise", 32'(phv_out_valid), 32'd1);
    check("t1_ready_out_low", 32'(ready_out), 32'd0);
    @(negedge clk);
    check("t1_valid_fall", 32'(phv_out_valid), 32'd0);
    check("t1_ready_out_back", 32'(ready_out), 32'd1);
    check("t1_drop_cnt", 32'(drop_cnt), 32'd0);
    sync();

    // Staggered arrival: 2B at t0, 6B at t2, 4B at t5
    exp_q.push_back(mk(8'h66, 8'h77, 8'h44, 8'h55));
    for (int k = 0; k < 6; k++) begin
      set_in(k == 2, k == 5, k == 0, 8'h66, 8'h77, 8'h44, 8'h55);
      @(negedge clk);
      check("t2_ready_out_collect", 32'(ready_out), 32'd1);
      check("t2_no_early_valid", 32'(phv_out_valid), 32'd0);
      sync();
      alu_6B_valid = 1'b0; alu_4B_valid = 1'b0; alu_2B_valid = 1'b0;
    end
    @(negedge clk);
    check("t2_valid_t6", 32'(phv_out_valid), 32'd1);
    check("t2_ready_out_t6", 32'(ready_out), 32'd0);
    sync();

    // Backpressure for 10 cycles with a 6B pulse dropped in EMIT
    ready_in = 1'b0;
    exp_q.push_back(mk(8'h88, 8'h99, 8'hAA, 8'hBB));
    drive_cycle(1'b1, 1'b1, 1'b1, 8'h88, 8'h99, 8'hAA, 8'hBB);
    for (int c = 0; c < 10; c++) begin
      set_in(c == 3, 1'b0, 1'b0, 8'hCC, 8'h00, 8'h00, 8'h00);
      @(negedge clk);
      check_wide("t3_phv_stable", phv_out, mk(8'h88, 8'h99, 8'hAA, 8'hBB));
      check("t3_valid_held", 32'(phv_out_valid), 32'd1);
      sync();
      alu_6B_valid = 1'b0;
    end
    @(negedge clk);
    check("t3_drop_cnt", 32'(drop_cnt), 32'd1);
    sync();
    ready_in = 1'b1;
    sync();
    @(negedge clk);
    check("t3_valid_after_hs", 32'(phv_out_valid), 32'd0);
    check("t3_ready_out_after_hs", 32'(ready_out), 32'd1);
    sync();
    exp_q.push_back(mk(8'hDD, 8'hEE, 8'hF0, 8'h0F));
    drive_cycle(1'b1, 1'b1, 1'b1, 8'hDD, 8'hEE, 8'hF0, 8'h0F);
    @(negedge clk);
    sync();

    // Second 4B while flag set: first data retained
    exp_q.push_back(mk(8'h56, 8'h12, 8'h78, 8'h9A));
    drive_cycle(1'b0, 1'b1, 1'b0, 8'h00, 8'h12, 8'h00, 8'h00);
    drive_cycle(1'b0, 1'b1, 1'b0, 8'h00, 8'h34, 8'h00, 8'h00);
    @(negedge clk);
    check("t4_drop_cnt", 32'(drop_cnt), 32'd2);
    check("t4_no_valid", 32'(phv_out_valid), 32'd0);
    sync();
    drive_cycle(1'b1, 1'b0, 1'b1, 8'h56, 8'h34, 8'h78, 8'h9A);
    @(negedge clk);
    sync();

`ifdef ACTION_MERGE_TIMEOUT_EN
    // Only 6B sent: flush 8 cycles after capture
    drive_cycle(1'b1, 1'b0, 1'b0, 8'h61, 8'h00, 8'h00, 8'h00);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("t5_timeout_err", 32'(timeout_err), 32'(k == 8));
      sync();
    end
    @(negedge clk);
    check("t5_ready_out", 32'(ready_out), 32'd1);
    check("t5_drop_cnt", 32'(drop_cnt), 32'd2);
    sync();
    exp_q.push_back(mk(8'h62, 8'h63, 8'h64, 8'h65));
    drive_cycle(1'b0, 1'b1, 1'b1, 8'h00, 8'h63, 8'h64, 8'h65);
    @(negedge clk);
    check("t5_flags_cleared", 32'(phv_out_valid), 32'd0);
    sync();
    drive_cycle(1'b1, 1'b0, 1'b0, 8'h62, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    sync();
`endif

    // Async reset with two flags set
    drive_cycle(1'b0, 1'b1, 1'b1, 8'h00, 8'h41, 8'h42, 8'h43);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_ready_out", 32'(ready_out), 32'd1);
    check("t6_rst_drop_cnt", 32'(drop_cnt), 32'd0);
    check("t6_rst_valid", 32'(phv_out_valid), 32'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    sync();
    drive_cycle(1'b0, 1'b1, 1'b0, 8'h00, 8'h44, 8'h00, 8'h00);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t6_no_output", 32'(phv_out_valid), 32'd0);
      sync();
    end

    // Async reset while holding a PHV in EMIT
    ready_in = 1'b0;
    exp_q.push_back(mk(8'h45, 8'h44, 8'h46, 8'h47));
    drive_cycle(1'b1, 1'b0, 1'b1, 8'h45, 8'h99, 8'h46, 8'h47);
    @(negedge clk);
    check("t7_valid", 32'(phv_out_valid), 32'd1);
    check_wide("t7_phv", phv_out, mk(8'h45, 8'h44, 8'h46, 8'h47));
    #1 rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("t7_rst_valid", 32'(phv_out_valid), 32'd0);
    check("t7_rst_ready_out", 32'(ready_out), 32'd1);
    check_wide("t7_rst_phv", phv_out, '0);
    #1 rst_n = 1'b1;
    sync();

    // drop_cnt saturation while stalled in EMIT
    exp_q.push_back(mk(8'hC1, 8'hC2, 8'hC3, 8'hC4));
    drive_cycle(1'b1, 1'b1, 1'b1, 8'hC1, 8'hC2, 8'hC3, 8'hC4);
    repeat (21844) drive_cycle(1'b1, 1'b1, 1'b1, 8'hEE, 8'hEE, 8'hEE, 8'hEE);
    @(negedge clk);
    check("t8_drop_cnt_pre", 32'(drop_cnt), 32'd65532);
    sync();
    drive_cycle(1'b1, 1'b1, 1'b1, 8'hEE, 8'hEE, 8'hEE, 8'hEE);
    @(negedge clk);
    check("t8_drop_cnt_sat", 32'(drop_cnt), 32'd65535);
    sync();
    repeat (5) drive_cycle(1'b1, 1'b1, 1'b1, 8'hEE, 8'hEE, 8'hEE, 8'hEE);
    @(negedge clk);
    check("t8_drop_cnt_hold", 32'(drop_cnt), 32'd65535);
    sync();
    ready_in = 1'b1;
    @(negedge clk);
    sync();
    @(negedge clk);
    check("t8_ready_out", 32'(ready_out), 32'd1);
    sync();

    // Final report
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/action_phv_merger.md
Name: action_phv_merger

Overview:
- Sits directly downstream of the action-stage crossbar and its ALU array.
- Collects the three independently timed ALU result groups (6B, 4B, 2B) plus the untouched 256-bit metadata, and rebuilds one PHV for the next stage.
- Each PHV is emitted exactly once, with a valid/ready handshake to the next stage and backpressure to the ALUs.

Parameters:
- STAGE_ID, 0, stage index, informational only
- NUM_PER_TYPE, 8, containers per type
- width_2B, 16, 2B container width
- width_4B, 32, 4B container width
- width_6B, 48, 6B container width
- PHV_LEN, 48*NUM_PER_TYPE+32*NUM_PER_TYPE+16*NUM_PER_TYPE+256, output PHV width
- TIMEOUT_CYCLES, 64, partial-collection timeout; used only with the optional feature

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- alu_6B_in  in  width_6B*NUM_PER_TYPE  6B ALU results
- alu_6B_valid  in  1  6B group valid
- alu_4B_in  in  width_4B*NUM_PER_TYPE  4B ALU results
- alu_4B_valid  in  1  4B group valid
- alu_2B_in  in  width_2B*NUM_PER_TYPE  2B ALU results
- phv_remain_in  in  256  metadata; travels with the 2B group
- alu_2B_valid  in  1  2B group and metadata valid
- ready_out  out  1  merger can accept groups
- phv_out  out  PHV_LEN  assembled PHV
- phv_out_valid  out  1  phv_out valid
- ready_in  in  1  next stage accepts phv_out
- drop_cnt  out  16  saturating count of dropped group arrivals
- timeout_err  out  1  one-cycle pulse on timeout flush

Behaviour:
- Clock and reset are fixed: one clock, clk; rst_n is asynchronous and active-low.
- Reset values: phv_out=0, phv_out_valid=0, ready_out=1, drop_cnt=0, timeout_err=0, all captured flags=0, state=COLLECT.
- Output layout: phv_out = {6B group, 4B group, 2B group, remain}, 6B group at the MSBs. Container i of each group occupies bits [(i+1)*w-1 -: w] within that group.
- FSM has two states: COLLECT and EMIT.
- COLLECT:
  - A group with valid=1 and its flag clear is latched into its holding register, and its flag is set.
  - A group with valid=1 and its flag already set is dropped; the held data is unchanged and drop_cnt increments.
  - Any group set may arrive in the same cycle, including all three.
  - In the cycle in which the last outstanding flag becomes set: next state is EMIT, phv_out is loaded, phv_out_valid=1 and ready_out=0 on the following edge.
  - Latency: phv_out_valid rises one cycle after the final group is captured.
- EMIT:
  - phv_out and phv_out_valid are held stable until ready_in=1.
  - When ready_in=1: on the next edge phv_out_valid=0, all flags clear, ready_out=1, state returns to COLLECT.
  - There is no same-cycle re-accept of groups on that handshake edge.
  - Any group valid seen in EMIT is dropped and drop_cnt increments. Simultaneous drops in one cycle count as 1 per dropped group.
- drop_cnt saturates at 16'hFFFF; it never wraps.
- ready_out is registered and equals (state==COLLECT).
- rst_n deasserted mid-collection or mid-EMIT: all state returns to reset values immediately; partial groups are discarded.

Optional Feature:
- Macro: ACTION_MERGE_TIMEOUT_EN.
- Enabled:
  - A counter is cleared when the first flag of a PHV is set and increments every COLLECT cycle while some, but not all, flags are set.
  - When the counter reaches TIMEOUT_CYCLES-1 without completion, all flags clear on the next edge and timeout_err pulses 1 for one cycle. Nothing is emitted and drop_cnt is unchanged.
  - Completion in the same cycle as the timeout has priority: the PHV is emitted and there is no pulse.
- Disabled: no counter is built, timeout_err is tied 0, and partial collections wait indefinitely.

Test Plan:
- All three valids in one cycle (6B=0x111…, 4B=0x222…, 2B=0x333…, remain=0xAB…), ready_in=1 -> phv_out_valid one cycle later for exactly one cycle, phv_out={0x111…,0x222…,0x333…,0xAB…}, ready_out back to 1 the cycle after.
- 2B at t0, 6B at t2, 4B at t5 -> phv_out_valid at t6 with the correct concatenation; ready_out=1 through t5, 0 at t6.
- ready_in=0 for 10 cycles during EMIT -> phv_out stable for all 10 cycles; a 6B valid pulse at cycle 3 is dropped with drop_cnt=1; after ready_in=1, the next PHV uses only newly arriving groups.
- Second 4B valid arrives while the 4B flag is already set -> first data retained in the output PHV, drop_cnt=1.
- With ACTION_MERGE_TIMEOUT_EN, TIMEOUT_CYCLES=8: only the 6B group is sent -> timeout_err pulse 8 cycles after capture, flags cleared; a later full set emits normally.
- rst_n pulled low with two flags set -> ready_out=1 and drop_cnt=0 asynchronously; then a single 4B group produces no output.
